conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Streaming 3x3 window generator that feeds the 9-pixel operand bus of the convolution MAC (px0..px8, unsigned 8-bit).
- Accepts a raster-order pixel stream (row-major, one pixel per handshake).
- Buffers the two previous image rows and emits every fully-populated 3x3 window (valid convolution, no padding) with a valid/ready handshake.
- Sits between the image source and the MAC; the weight bus is out of scope.

Parameters:
- IMG_W, 8, image width in pixels; legal values are 3 or more.
- IMG_H, 8, image height in rows; legal values are 3 or more.
- PIX_W, 8, pixel width in bits; unsigned.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_pix  in  PIX_W  input pixel, raster order
- in_valid  in  1  in_pix is valid
- in_ready  out  1  block can accept in_pix this cycle
- px0..px8  out  PIX_W each  window pixels; px0..px2 = top row, px3..px5 = middle row, px6..px8 = bottom row, left to right
- out_valid  out  1  px0..px8 hold a valid window
- out_ready  in  1  downstream consumes the window
- out_last  out  1  qualifies the final window of a frame; meaningful only while out_valid=1

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_last=0, px0..px8=0.
  - Row counter r=0, column counter c=0.
  - Line-buffer RAM contents are not reset; counters gate their use.
- Accept condition: in_valid && in_ready.
- Backpressure: in_ready = !out_valid || out_ready. This is combinational, with no bubble under continuous flow.
- On each accepted pixel P at (r,c):
  - The 3-column shift window shifts left by one column.
  - New right column = {lb2[c], lb1[c], P} (top, middle, bottom).
  - lb2[c] <= lb1[c]; lb1[c] <= P.
- Window emit:
  - If an accept occurs at r>=2 && c>=2, the next cycle presents out_valid=1 with the window for that accept. Latency is 1 cycle from accept.
  - Window contents:
    - px0=P(r-2,c-2), px1=P(r-2,c-1), px2=P(r-2,c)
    - px3..px5 = the same columns from row r-1
    - px6..px8 = the same columns from row r
- If an accept occurs with r<2 or c<2, out_valid is 0 next cycle, unless a held window is still pending; that case cannot arise because in_ready=0 while a window is held.
- Hold rule: while out_valid=1 && out_ready=0, px0..px8, out_valid and out_last are stable and no pixel is accepted.
- Simultaneous consume and accept: the new window (or out_valid=0) replaces the old one in the same cycle.
- Counter wrap:
  - c wraps IMG_W-1 -> 0 and increments r.
  - r wraps IMG_H-1 -> 0 (next frame) on the accept at (IMG_H-1, IMG_W-1).
  - There is no gap between frames.
- out_last=1 with the window produced by the accept at (IMG_H-1, IMG_W-1).
- Windows per frame = (IMG_W-2)*(IMG_H-2), emitted in raster order of the window centre.
- Frame boundary: line buffers carry over stale rows from the previous frame. They are never used, because no window is emitted before r=2 of the new frame, by which point both buffers have been rewritten.
- Row boundary: at c=0 and c=1 the shift window contains columns from the previous row. No window is emitted there.
- Reset mid-frame: in-flight window dropped, counters return to (0,0), and the next accepted pixel is treated as pixel (0,0).
- Line buffers: two IMG_W x PIX_W arrays, inferred as distributed or block RAM, one read and one write per accept.

Optional Feature:
- Macro: WIN_COORD_EN.
- Defined:
  - Adds output ports win_row and win_col, each $clog2(IMG_H) / $clog2(IMG_W) bits wide.
  - They give the centre coordinate (r-1, c-1) of the presented window.
  - Registered with px*, held under backpressure, reset to 0.
- Undefined: these ports do not exist and no coordinate registers are built; all other behaviour is identical.

Test Plan:
- IMG_W=IMG_H=4, pixels 1..16 streamed, out_ready=1 -> exactly 4 windows.
  - First: 1,2,3,5,6,7,9,10,11, out_valid one cycle after pixel 11 is accepted.
  - Second: 2,3,4,6,7,8,10,11,12.
  - Third: 5,6,7,9,10,11,13,14,15.
  - Fourth: 6,7,8,10,11,12,14,15,16, with out_last=1.
- Same stream, out_ready held 0 for 5 cycles after the first window -> in_ready=0, window 1,2,3,5,6,7,9,10,11 stable for all 5 cycles, no pixel lost; remaining 3 windows are correct afterwards.
- Two back-to-back 4x4 frames (1..16 then 101..116) -> 8 windows total.
  - Frame-2 first window is 101,102,103,105,106,107,109,110,111.
  - out_last is asserted only on windows 4 and 8.
- rst pulsed after 7 pixels, then the full 1..16 frame is streamed -> out_valid=0 and px*=0 during reset; output matches the first scenario exactly.
- in_valid toggled 1/0 every cycle with out_ready random -> same 4 windows in order, no duplicates or drops.
- WIN_COORD_EN defined, first scenario -> (win_row,win_col) = (1,1), (1,2), (2,1), (2,2).

Source files
------------

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator for the convolution MAC.
// It takes a raster-order pixel stream, keeps the two previous rows in line
// buffers, and emits every fully populated 3x3 window through a valid/ready
// output. No padding is applied.
// Optional macro WIN_COORD_EN adds the win_row/win_col centre-coordinate outputs.
module conv_window_gen #(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] px0,
  output logic [PIX_W-1:0] px1,
  output logic [PIX_W-1:0] px2,
  output logic [PIX_W-1:0] px3,
  output logic [PIX_W-1:0] px4,
  output logic [PIX_W-1:0] px5,
  output logic [PIX_W-1:0] px6,
  output logic [PIX_W-1:0] px7,
  output logic [PIX_W-1:0] px8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef WIN_COORD_EN
  ,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  // Raster position of the next pixel to be accepted.
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2 (indexed by column).
  logic [PIX_W-1:0] lb1_q [0:IMG_W-1];
  logic [PIX_W-1:0] lb2_q [0:IMG_W-1];

  // Two stored columns of the shift window; element [2]=top, [1]=mid, [0]=bottom.
  logic [2:0][PIX_W-1:0] col0_q, col0_d;
  logic [2:0][PIX_W-1:0] col1_q, col1_d;
  logic [2:0][PIX_W-1:0] new_col_c;

  // Presented window; element k drives pxk.
  logic [8:0][PIX_W-1:0] win_q, win_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  logic accept_c;
  logic emit_c;
  logic frame_end_c;
  logic col_end_c;
  logic row_end_c;

`ifdef WIN_COORD_EN
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
`endif

  // Handshake and position decode.
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    accept_c    = in_valid && in_ready;
    col_end_c   = (c_q == CW'(IMG_W - 1));
    row_end_c   = (r_q == RW'(IMG_H - 1));
    emit_c      = (r_q >= RW'(2)) && (c_q >= CW'(2));
    frame_end_c = col_end_c && row_end_c;
    new_col_c   = {lb2_q[c_q], lb1_q[c_q], in_pix};
  end

  // Next-state for counters, shift window and output window.
  always_comb begin
    c_d         = c_q;
    r_d         = r_q;
    col0_d      = col0_q;
    col1_d      = col1_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef WIN_COORD_EN
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
`endif
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (accept_c) begin
      col0_d      = col1_q;
      col1_d      = new_col_c;
      out_valid_d = emit_c;
      out_last_d  = emit_c && frame_end_c;
      if (emit_c) begin
        win_d = {new_col_c[0], col1_q[0], col0_q[0],
                 new_col_c[1], col1_q[1], col0_q[1],
                 new_col_c[2], col1_q[2], col0_q[2]};
`ifdef WIN_COORD_EN
        win_row_d = r_q - RW'(1);
        win_col_d = c_q - CW'(1);
`endif
      end
      if (col_end_c) begin
        c_d = '0;
        r_d = row_end_c ? '0 : r_q + RW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end
    end
  end

  // Control and window registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q         <= '0;
      r_q         <= '0;
      col0_q      <= '0;
      col1_q      <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef WIN_COORD_EN
      win_row_q   <= '0;
      win_col_q   <= '0;
`endif
    end else begin
      c_q         <= c_d;
      r_q         <= r_d;
      col0_q      <= col0_d;
      col1_q      <= col1_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef WIN_COORD_EN
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
`endif
    end
  end

  // Line-buffer RAMs: one read and one write per accept, contents not reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      lb2_q[c_q] <= lb1_q[c_q];
      lb1_q[c_q] <= in_pix;
    end
  end

  // Output mapping.
  always_comb begin
    px0       = win_q[0];
    px1       = win_q[1];
    px2       = win_q[2];
    px3       = win_q[3];
    px4       = win_q[4];
    px5       = win_q[5];
    px6       = win_q[6];
    px7       = win_q[7];
    px8       = win_q[8];
    out_valid = out_valid_q;
    out_last  = out_last_q;
`ifdef WIN_COORD_EN
    win_row   = win_row_q;
    win_col   = win_col_q;
`endif
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Testbench for conv_window_gen on a 4x4 image: table of expected windows,
// a small handshake model, and directed stall/reset/multi-frame sequences.
module tb_conv_window_gen;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NPF = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_pix = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] px0, px1, px2, px3, px4, px5, px6, px7, px8;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
`ifdef WIN_COORD_EN
  logic [1:0] win_row;
  logic [1:0] win_col;
`endif

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
    .px0(px0), .px1(px1), .px2(px2), .px3(px3), .px4(px4),
    .px5(px5), .px6(px6), .px7(px7), .px8(px8),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
`ifdef WIN_COORD_EN
    , .win_row(win_row), .win_col(win_col)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] px;
    logic        last;
    logic [1:0]  row;
    logic [1:0]  col;
  } win_t;

  win_t exp_tab [8];
  int   pix [2*NPF];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [71:0] pxbus;
  assign pxbus = {px8, px7, px6, px5, px4, px3, px2, px1, px0};

  function automatic logic [71:0] mkw(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5,
                                      input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Asynchronous reset pulse; outputs must clear while rst is high.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 72'(out_valid), 72'd0);
    chk("rst_last", 72'(out_last), 72'd0);
    chk("rst_px", pxbus, 72'd0);
    @(negedge clk);
    chk("rst_valid_hold", 72'(out_valid), 72'd0);
    chk("rst_px_hold", pxbus, 72'd0);
`ifdef WIN_COORD_EN
    chk("rst_coord", 72'({win_row, win_col}), 72'd0);
`endif
    rst = 1'b0;
  endtask

  // Streams npix pixels from pix[] starting at frame position (0,0) and checks
  // windows exp_tab[0..exp_n-1]. vmode: 0 = in_valid always, 1 = toggled.
  // rmode: 0 = out_ready always, 1 = stall 5 cycles on first window, 2 = random.
  task automatic run_stream(input int npix, input int exp_n, input int vmode, input int rmode);
    int          pi = 0;
    int          wi = 0;
    int          cyc = 0;
    int          stall = 0;
    bit          tog = 1'b1;
    bit          exp_ov = 1'b0;
    bit          exp_last = 1'b0;
    bit          holding = 1'b0;
    logic [71:0] held_px = '0;
    logic        held_last = 1'b0;
    int          k;
    bit          acc;
    while (!(pi >= npix && wi >= exp_n)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout: pixels %0d/%0d windows %0d/%0d", pi, npix, wi, exp_n);
        break;
      end
      chk("out_valid", 72'(out_valid), 72'(exp_ov));
      if (exp_ov) chk("out_last", 72'(out_last), 72'(exp_last));
      if (holding) begin
        chk("hold_px", pxbus, held_px);
        chk("hold_last", 72'(out_last), 72'(held_last));
      end
      case (rmode)
        1: begin
          if (exp_ov && wi == 0 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (pi < npix) begin
        in_valid = (vmode == 0) ? 1'b1 : tog;
        in_pix = 8'(pix[pi]);
      end else begin
        in_valid = 1'b0;
        in_pix = '0;
      end
      tog = !tog;
      #1;
      chk("in_ready", 72'(in_ready), 72'(!exp_ov || out_ready));
      if (out_valid && out_ready) begin
        if (wi >= exp_n) begin
          chk("extra_window", 72'(wi), 72'(exp_n - 1));
        end else begin
          chk($sformatf("win%0d_px", wi), pxbus, exp_tab[wi].px);
          chk($sformatf("win%0d_last", wi), 72'(out_last), 72'(exp_tab[wi].last));
`ifdef WIN_COORD_EN
          chk($sformatf("win%0d_coord", wi), 72'({win_row, win_col}),
              72'({exp_tab[wi].row, exp_tab[wi].col}));
`endif
        end
        wi++;
      end
      holding = exp_ov && !out_ready;
      held_px = pxbus;
      held_last = out_last;
      acc = in_valid && (!exp_ov || out_ready);
      if (acc) begin
        k = pi % NPF;
        exp_ov = ((k / W) >= 2) && ((k % W) >= 2);
        exp_last = (k == NPF - 1);
        pi++;
      end else if (exp_ov && out_ready) begin
        exp_ov = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    exp_tab[0] = '{px: mkw(1, 2, 3, 5, 6, 7, 9, 10, 11),           last: 1'b0, row: 2'd1, col: 2'd1};
    exp_tab[1] = '{px: mkw(2, 3, 4, 6, 7, 8, 10, 11, 12),          last: 1'b0, row: 2'd1, col: 2'd2};
    exp_tab[2] = '{px: mkw(5, 6, 7, 9, 10, 11, 13, 14, 15),        last: 1'b0, row: 2'd2, col: 2'd1};
    exp_tab[3] = '{px: mkw(6, 7, 8, 10, 11, 12, 14, 15, 16),       last: 1'b1, row: 2'd2, col: 2'd2};
    exp_tab[4] = '{px: mkw(101, 102, 103, 105, 106, 107, 109, 110, 111), last: 1'b0, row: 2'd1, col: 2'd1};
    exp_tab[5] = '{px: mkw(102, 103, 104, 106, 107, 108, 110, 111, 112), last: 1'b0, row: 2'd1, col: 2'd2};
    exp_tab[6] = '{px: mkw(105, 106, 107, 109, 110, 111, 113, 114, 115), last: 1'b0, row: 2'd2, col: 2'd1};
    exp_tab[7] = '{px: mkw(106, 107, 108, 110, 111, 112, 114, 115, 116), last: 1'b1, row: 2'd2, col: 2'd2};
    for (int i = 0; i < NPF; i++) begin
      pix[i] = i + 1;
      pix[NPF + i] = 101 + i;
    end

    do_reset();
    run_stream(NPF, 4, 0, 0);       // single frame, free flow
    run_stream(NPF, 4, 0, 1);       // backpressure on first window
    run_stream(2 * NPF, 8, 0, 0);   // two back-to-back frames
    run_stream(7, 0, 0, 0);         // partial frame, then reset
    do_reset();
    run_stream(NPF, 4, 0, 0);
    run_stream(NPF, 4, 1, 2);       // toggled in_valid, random out_ready

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
